// File: rtl/nwc_job_controller.sv
// Job sequencer for the NWC processor: loads WORDS operand pairs, pulses start, then forwards
// WORDS results. Optional COMPUTE watchdog enabled by defining NWC_CTRL_TIMEOUT_EN.
module nwc_job_controller #(
  parameter int unsigned WORDS          = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_req,
  output logic        job_ack,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_data0,
  input  logic [59:0] in_data1,
  output logic        nwc_write_enable,
  output logic [59:0] nwc_data_in0,
  output logic [59:0] nwc_data_in1,
  output logic        nwc_start,
  input  logic [59:0] nwc_data_out,
  input  logic        nwc_output_active,
  output logic        out_valid,
  output logic [59:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CntW = $clog2(WORDS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StCompute,
    StDrain,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [CntW-1:0] r_load_cnt;
  logic [CntW-1:0] r_out_cnt;
  logic            r_job_ack;
  logic            r_we;
  logic [59:0]     r_d0;
  logic [59:0]     r_d1;
  logic            r_start;
  logic            r_out_valid;
  logic [59:0]     r_out_data;
  logic            r_out_last;
  logic            r_error;

  logic w_job_go;
  logic w_accept;
  logic w_fwd;
  logic w_drain_err;
  logic w_timeout;

  assign w_job_go    = (r_state == StIdle) && job_req;
  assign w_accept    = (r_state == StLoad) && in_valid;
  // Once the final word is being presented (r_out_last), the producer is no longer watched.
  assign w_fwd       = nwc_output_active &&
                       ((r_state == StCompute) || ((r_state == StDrain) && !r_out_last));
  assign w_drain_err = (r_state == StDrain) && !r_out_last && !nwc_output_active;

`ifdef NWC_CTRL_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != StCompute) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end

  assign w_timeout = (r_state == StCompute) && !nwc_output_active && (r_to_cnt == ToLast);
`else
  // Watchdog absent; the parameter stays in the interface so both builds share instantiations.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (job_req) w_state_d = StLoad;
      StLoad:    if (w_accept && (r_load_cnt == LastCnt)) w_state_d = StStart;
      StStart:   w_state_d = StCompute;
      StCompute: begin
        if (nwc_output_active) begin
          w_state_d = StDrain;
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      StDrain: begin
        if (r_out_last) begin
          w_state_d = StDone;
        end else if (!nwc_output_active) begin
          w_state_d = StIdle;
        end
      end
      StDone:    w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt  <= '0;
      r_out_cnt   <= '0;
      r_job_ack   <= 1'b0;
      r_we        <= 1'b0;
      r_d0        <= '0;
      r_d1        <= '0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_job_ack   <= w_job_go;
      r_we        <= w_accept;
      r_start     <= (r_state == StStart);
      r_out_valid <= w_fwd;
      r_out_last  <= w_fwd && (r_out_cnt == LastCnt);
      if (w_accept) begin
        r_d0 <= in_data0;
        r_d1 <= in_data1;
      end
      if (w_fwd) begin
        r_out_data <= nwc_data_out;
      end
      if (w_job_go) begin
        r_load_cnt <= '0;
        r_out_cnt  <= '0;
      end else begin
        if (w_accept) r_load_cnt <= r_load_cnt + CntW'(1);
        if (w_fwd)    r_out_cnt  <= r_out_cnt + CntW'(1);
      end
      if (w_job_go) begin
        r_error <= 1'b0;
      end else if (w_drain_err || w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign job_ack          = r_job_ack;
  assign in_ready         = (r_state == StLoad);
  assign nwc_write_enable = r_we;
  assign nwc_data_in0     = r_d0;
  assign nwc_data_in1     = r_d1;
  assign nwc_start        = r_start;
  assign out_valid        = r_out_valid;
  assign out_data         = r_out_data;
  assign out_last         = r_out_last;
  assign busy             = (r_state != StIdle);
  assign done             = (r_state == StDone);
  assign error            = r_error;

endmodule

// File: tb/tb_nwc_job_controller.sv
// Directed bench for nwc_job_controller: a job-level reference model checked every cycle,
// plus literal expectations per scenario. Honours NWC_CTRL_TIMEOUT_EN.
module tb_nwc_job_controller;

  localparam int W = 2048;
`ifdef NWC_CTRL_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65536;
`endif

  // Reference model phases
  localparam int PhIdle = 0, PhLoad = 1, PhStart = 2, PhComp = 3, PhDrain = 4, PhDone = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_req = 1'b0;
  logic        job_ack;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] in_data0 = '0;
  logic [59:0] in_data1 = '0;
  logic        nwc_write_enable;
  logic [59:0] nwc_data_in0;
  logic [59:0] nwc_data_in1;
  logic        nwc_start;
  logic [59:0] nwc_data_out = '0;
  logic        nwc_output_active = 1'b0;
  logic        out_valid;
  logic [59:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;

  nwc_job_controller #(
    .WORDS         (W),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .job_req          (job_req),
    .job_ack          (job_ack),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data0         (in_data0),
    .in_data1         (in_data1),
    .nwc_write_enable (nwc_write_enable),
    .nwc_data_in0     (nwc_data_in0),
    .nwc_data_in1     (nwc_data_in1),
    .nwc_start        (nwc_start),
    .nwc_data_out     (nwc_data_out),
    .nwc_output_active(nwc_output_active),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Observation counters written only by the compare process
  int cyc = 0;
  int mon_we = 0, mon_start = 0, mon_ov = 0, mon_last = 0;
  int last_we_cyc = 0, start_cyc = 0, last_cyc = 0, done_cyc = 0;
  logic [59:0] last_we_d0 = '0, last_we_d1 = '0, last_out = '0;

  // Reference model state and next-cycle expectations
  int ph = PhIdle, acc = 0, fwd = 0, tcnt = 0;
  logic m_err = 1'b0;
  logic e_ack = 1'b0, e_we = 1'b0, e_start = 1'b0, e_ov = 1'b0, e_last = 1'b0;
  logic [59:0] e_d0 = '0, e_d1 = '0, e_od = '0;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ph = PhIdle; acc = 0; fwd = 0; tcnt = 0; m_err = 1'b0;
        e_ack = 1'b0; e_we = 1'b0; e_start = 1'b0; e_ov = 1'b0; e_last = 1'b0;
        e_d0 = '0; e_d1 = '0; e_od = '0;
      end
      chk("job_ack", 64'(job_ack), 64'(e_ack));
      chk("in_ready", 64'(in_ready), 64'(ph == PhLoad));
      chk("nwc_write_enable", 64'(nwc_write_enable), 64'(e_we));
      chk("nwc_data_in0", 64'(nwc_data_in0), 64'(e_d0));
      chk("nwc_data_in1", 64'(nwc_data_in1), 64'(e_d1));
      chk("nwc_start", 64'(nwc_start), 64'(e_start));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) chk("out_data", 64'(out_data), 64'(e_od));
      chk("out_last", 64'(out_last), 64'(e_last));
      chk("busy", 64'(busy), 64'(ph != PhIdle));
      chk("done", 64'(done), 64'(ph == PhDone));
      chk("error", 64'(error), 64'(m_err));

      if (nwc_write_enable) begin
        mon_we++; last_we_cyc = cyc; last_we_d0 = nwc_data_in0; last_we_d1 = nwc_data_in1;
      end
      if (nwc_start) begin mon_start++; start_cyc = cyc; end
      if (out_valid) mon_ov++;
      if (out_last) begin mon_last++; last_cyc = cyc; last_out = out_data; end
      if (done) done_cyc = cyc;

      if (rst_n) begin
        e_ack = 1'b0; e_we = 1'b0; e_start = 1'b0; e_ov = 1'b0; e_last = 1'b0;
        case (ph)
          PhIdle: if (job_req) begin
            e_ack = 1'b1; m_err = 1'b0; acc = 0; fwd = 0; ph = PhLoad;
          end
          PhLoad: if (in_valid) begin
            e_we = 1'b1; e_d0 = in_data0; e_d1 = in_data1; acc++;
            if (acc == W) ph = PhStart;
          end
          PhStart: begin e_start = 1'b1; tcnt = 0; ph = PhComp; end
          PhComp: begin
            if (nwc_output_active) begin
              e_ov = 1'b1; e_od = nwc_data_out; fwd = 1; e_last = (W == 1); ph = PhDrain;
            end
`ifdef NWC_CTRL_TIMEOUT_EN
            else begin
              tcnt++;
              if (tcnt == TO) begin m_err = 1'b1; ph = PhIdle; end
            end
`endif
          end
          PhDrain: begin
            if (fwd == W) ph = PhDone;
            else if (nwc_output_active) begin
              e_ov = 1'b1; e_od = nwc_data_out; fwd++; e_last = (fwd == W);
            end else begin
              m_err = 1'b1; ph = PhIdle;
            end
          end
          default: ph = PhIdle;
        endcase
      end
    end
  end

  // All drive tasks enter and leave 1 time unit after a rising edge.
  task automatic pulse_req();
    job_req = 1'b1;
    @(posedge clk); #1;
    job_req = 1'b0;
    @(negedge clk);
    chk("ack_next_cycle", 64'(job_ack), 64'd1);
    chk("error_cleared", 64'(error), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic load(input int n, input bit gaps, input bit noise);
    int i = 0;
    int c = 0;
    bit a;
    while (i < n && c < 4 * n + 20) begin
      in_valid = gaps ? (c % 3 != 2) : 1'b1;
      in_data0 = 60'(i);
      in_data1 = 60'(W + i);
      if (noise) begin nwc_output_active = 1'b1; nwc_data_out = 60'hABC; end
      @(negedge clk);
      a = in_valid && in_ready;
      @(posedge clk); #1;
      if (a) i++;
      c++;
    end
    chk("load_accepts", 64'(i), 64'(n));
    in_valid = 1'b0;
    if (noise) begin @(posedge clk); #1; end
    nwc_output_active = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int g = 0; g < 40 && !seen; g++) begin
      @(negedge clk);
      if (nwc_start) seen = 1;
    end
    chk("start_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n, input bit hold_req);
    if (hold_req) job_req = 1'b1;
    wait_start();
    for (int k = 0; k < n; k++) begin
      nwc_output_active = 1'b1;
      nwc_data_out = 60'(k);
      @(posedge clk); #1;
    end
    nwc_output_active = 1'b0;
  endtask

  int s_we, s_start, s_ov, s_last;
  bit seen_ack;

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "time limit");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    @(posedge clk); #1;

    // Back-to-back load, full drain, job_req held across DONE
    s_we = mon_we; s_start = mon_start; s_ov = mon_ov; s_last = mon_last;
    pulse_req();
    load(W, 1'b0, 1'b0);
    drain(W, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("s1_writes", 64'(mon_we - s_we), 64'(W));
    chk("s1_last_d0", 64'(last_we_d0), 64'd2047);
    chk("s1_last_d1", 64'(last_we_d1), 64'd4095);
    chk("s1_starts", 64'(mon_start - s_start), 64'd1);
    chk("s1_start_after_write", 64'(start_cyc), 64'(last_we_cyc + 1));
    chk("s1_out_valids", 64'(mon_ov - s_ov), 64'(W));
    chk("s1_out_lasts", 64'(mon_last - s_last), 64'd1);
    chk("s1_last_data", 64'(last_out), 64'd2047);
    chk("s1_done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    seen_ack = 0;
    for (int g = 0; g < 10 && !seen_ack; g++) begin
      @(negedge clk);
      if (job_ack) seen_ack = 1;
    end
    chk("s1_auto_restart_ack", 64'(seen_ack), 64'd1);
    @(posedge clk); #1;
    job_req = 1'b0;

    // Gapped load with spurious output_active, truncated drain
    s_we = mon_we; s_ov = mon_ov; s_last = mon_last;
    load(W, 1'b1, 1'b1);
    drain(1000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("s2_writes", 64'(mon_we - s_we), 64'(W));
    chk("s2_start_after_write", 64'(start_cyc), 64'(last_we_cyc + 1));
    chk("s2_out_valids", 64'(mon_ov - s_ov), 64'd1000);
    chk("s2_no_last", 64'(mon_last - s_last), 64'd0);
    chk("s2_error", 64'(error), 64'd1);
    chk("s2_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // New job clears error, then reset mid-load
    pulse_req();
    load(500, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_job_ack", 64'(job_ack), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(nwc_write_enable), 64'd0);
    chk("rst_d0", 64'(nwc_data_in0), 64'd0);
    chk("rst_d1", 64'(nwc_data_in1), 64'd0);
    chk("rst_start", 64'(nwc_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh job after reset, then no result from the processor
    s_we = mon_we;
    pulse_req();
    load(W, 1'b0, 1'b0);
    wait_start();
    chk("s4_fresh_writes", 64'(mon_we - s_we), 64'(W));
`ifdef NWC_CTRL_TIMEOUT_EN
    repeat (105) @(negedge clk);
    chk("s4_timeout_error", 64'(error), 64'd1);
    chk("s4_timeout_idle", 64'(busy), 64'd0);
`else
    repeat (10000) @(negedge clk);
    chk("s4_still_busy", 64'(busy), 64'd1);
    chk("s4_no_error", 64'(error), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nwc_job_controller.md
NWC_JOB_CONTROLLER -- requirements
Module: nwc_job_controller

Interface
REQ-001 The block SHALL have parameter WORDS, default 2048, giving the operand words loaded and result words drained per job.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65536, giving the COMPUTE watchdog limit in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port job_req, input, 1 bit: the host requests a new job.
REQ-006 The block SHALL have port job_ack, output, 1 bit: one-cycle pulse when a job is accepted.
REQ-007 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit), in_data0 (input, 60 bits) and in_data1 (input, 60 bits): the operand stream with valid/ready handshake.
REQ-008 The block SHALL have ports nwc_write_enable (output, 1 bit), nwc_data_in0 (output, 60 bits), nwc_data_in1 (output, 60 bits) and nwc_start (output, 1 bit): drive to the NWC processor.
REQ-009 The block SHALL have ports nwc_data_out (input, 60 bits) and nwc_output_active (input, 1 bit): result from the NWC processor.
REQ-010 The block SHALL have ports out_valid (output, 1 bit), out_data (output, 60 bits) and out_last (output, 1 bit): the result stream, which has no backpressure.
REQ-011 The block SHALL have ports busy (output, 1 bit: state is not IDLE), done (output, 1 bit: one-cycle pulse when a job completes) and error (output, 1 bit: sticky fault flag).

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, START, COMPUTE, DRAIN and DONE.
REQ-013 In IDLE, when job_req=1 the FSM SHALL go to LOAD, pulse job_ack for one cycle, clear error, and zero both counters.
REQ-014 in_ready SHALL be 1 only in LOAD.
REQ-015 Each accept (in_valid & in_ready) SHALL cause, one cycle later, nwc_write_enable=1 for exactly one cycle, with nwc_data_in0/nwc_data_in1 holding the accepted words.
REQ-016 nwc_write_enable SHALL be 0 in all other cycles, and the nwc_data_in outputs SHALL hold their last value.
REQ-017 in_valid=0 in LOAD SHALL insert gaps and SHALL NOT be counted.
REQ-018 An 11-bit-plus load counter SHALL count accepts; on the WORDS-th accept the FSM SHALL go to START, and in_ready SHALL drop in the following cycle.
REQ-019 nwc_start SHALL be 1 for exactly one cycle, the cycle immediately after the final nwc_write_enable cycle; the FSM then SHALL go to COMPUTE.
REQ-020 In COMPUTE, the first cycle with nwc_output_active=1 SHALL move the FSM to DRAIN, and that cycle's word SHALL be forwarded.
REQ-021 Forwarding SHALL be registered with one-cycle latency: out_valid follows nwc_output_active and out_data follows nwc_data_out, in DRAIN and on the COMPUTE-to-DRAIN cycle.
REQ-022 out_last SHALL be 1 together with the WORDS-th out_valid, after which the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-024 If nwc_output_active falls in DRAIN before WORDS words have been forwarded, the block SHALL set error=1 and go to IDLE with no out_last.
REQ-025 nwc_output_active=1 in IDLE, LOAD or START SHALL be ignored: no out_valid and no error.
REQ-026 job_req in any state other than IDLE SHALL be ignored; job_req held high across DONE SHALL start the next job on the IDLE cycle.
REQ-027 out_valid, out_last and done SHALL be 0 outside the conditions defined in REQ-021 to REQ-023.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, zero both counters, and set all 1-bit outputs and all data outputs to 0.
REQ-029 Reset mid-job SHALL abandon the job silently.
REQ-030 The block SHALL NOT attempt to resynchronise the NWC processor's internal write address; a system-level reset of that processor is required after a reset during LOAD.

Configuration
REQ-031 With NWC_CTRL_TIMEOUT_EN defined, a counter SHALL run in COMPUTE; if TIMEOUT_CYCLES cycles elapse without nwc_output_active, the block SHALL set error=1 and return to IDLE.
REQ-032 Without NWC_CTRL_TIMEOUT_EN, COMPUTE SHALL wait indefinitely, the counter SHALL be absent, and the timeout SHALL never set error.

Verification
REQ-033 Bench scenario: job_req pulse, then 2048 back-to-back words with in_data0=i and in_data1=2048+i -> job_ack in cycle 1, 2048 nwc_write_enable pulses with matching data, and one nwc_start pulse exactly one cycle after the last write.
REQ-034 Bench scenario: in_valid deasserted every 3rd cycle during LOAD -> still exactly 2048 writes, and nwc_start only after the 2048th.
REQ-035 Bench scenario: model asserts nwc_output_active for 2048 cycles with nwc_data_out=k -> out_data=k one cycle later, out_last on k=2047, and done one cycle after out_last.
REQ-036 Bench scenario: nwc_output_active drops after 1000 words -> error=1, no out_last, busy=0 next cycle, and the next job_req clears error.
REQ-037 Bench scenario: rst_n asserted at load word 500 -> all outputs 0 asynchronously and state IDLE; a new job after reset accepts 2048 fresh words.
REQ-038 Bench scenario: with NWC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, no nwc_output_active -> error=1 after 100 COMPUTE cycles; without the macro -> busy stays 1 for 10000 cycles with error=0.
